// File: rtl/booth_r4_mac.sv
// booth_r4_mac: iterative radix-4 Booth multiplier / accumulator.
//
// One Booth digit is retired per clock. Operands are widened to WIDTH+2 bits
// (sign- or zero-extended by signed_mode), which gives a fixed N = WIDTH/2+1
// digits in both modes. The latency from the start edge to ready is therefore
// always N+1 cycles.
//
// Parameters:
//   WIDTH        operand width (even, >= 4); result width is 2*WIDTH
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's complement operands, 0 = unsigned (latched at start)
//   acc_en       1 = out <= out + product, 0 = out <= product (latched at start)
//   A, B         multiplicand / multiplier (latched at start)
//   busy         operation in progress
//   ready        one-cycle completion pulse
//   out          result register, held until the next completion
module booth_r4_mac #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   out
);
    localparam int PW = 2 * WIDTH;
    localparam int EW = WIDTH + 2;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;   // extended A, pre-scaled by 4^i
    logic [EW:0]     mplier_q, mplier_d; // {B_ext, b[-1]}; low 3 bits are the current triple
    logic [PW-1:0]   pp_q, pp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [PW-1:0]   out_q, out_d;
    logic            ready_q, ready_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            pp_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            out_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            pp_q     <= pp_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pp_d     = pp_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        out_d    = out_q;
        ready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Extending the multiplicand straight to the product
                    // width makes every add/subtract below plain mod-2^PW.
                    mcand_d  = {{WIDTH{signed_mode & A[WIDTH-1]}}, A};
                    mplier_d = {{2{signed_mode & B[WIDTH-1]}}, B, 1'b0};
                    pp_d     = '0;
                    cnt_d    = '0;
                    acc_d    = acc_en;
                    state_d  = CALC;
                end
            end
            CALC: begin
                unique case (mplier_q[2:0])
                    3'b001, 3'b010: pp_d = pp_q + mcand_q;
                    3'b011:         pp_d = pp_q + (mcand_q << 1);
                    3'b100:         pp_d = pp_q - (mcand_q << 1);
                    3'b101, 3'b110: pp_d = pp_q - mcand_q;
                    default:        pp_d = pp_q;
                endcase
                // Bit 2 of the old triple becomes b[2i-1] of the next one.
                mcand_d  = mcand_q << 2;
                mplier_d = {2'b00, mplier_q[EW:2]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_d   = acc_q ? (out_q + pp_q) : pp_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign ready = ready_q;
    assign out   = out_q;
endmodule

// File: tb/tb_booth_r4_mac.sv
// Directed and randomised bench for booth_r4_mac, covering a WIDTH=16 and a
// WIDTH=8 instance on a shared clock and reset.
module tb_booth_r4_mac;
    logic        clk, rst;
    logic        s16, sm16, ae16, busy16, rdy16;
    logic [15:0] a16, b16;
    logic [31:0] out16;
    logic        s8, sm8, ae8, busy8, rdy8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int n_cmp = 0;
    int n_bad = 0;

    booth_r4_mac #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .signed_mode(sm16), .acc_en(ae16),
        .A(a16), .B(b16), .busy(busy16), .ready(rdy16), .out(out16)
    );
    booth_r4_mac #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8), .acc_en(ae8),
        .A(a8), .B(b8), .busy(busy8), .ready(rdy8), .out(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one operation, wait (bounded) for ready, check latency, busy
    // during the run, the result, and that ready is a single-cycle pulse.
    task automatic run_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic ae, input logic [31:0] exp,
                          input string tag);
        int lat;
        bit busy_ok;
        int exp_lat;
        exp_lat = w8 ? 6 : 10;
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; ae8 = ae; s8 = 1'b1; end
        else    begin a16 = a;     b16 = b;     sm16 = sm; ae16 = ae; s16 = 1'b1; end
        tick;
        s8 = 1'b0; s16 = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (!(w8 ? rdy8 : rdy16) && lat < 40) begin
            if (!(w8 ? busy8 : busy16)) busy_ok = 1'b0;
            tick;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy during"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " out"}, w8 ? {16'h0, out8} : out16, exp);
        chk({tag, " busy at ready"}, {31'b0, w8 ? busy8 : busy16}, 32'd0);
        tick;
        chk({tag, " ready width"}, {31'b0, w8 ? rdy8 : rdy16}, 32'd0);
    endtask

    initial begin
        int lat;
        int cnt_r, cnt_b;
        logic [7:0]  ra, rb;
        logic        rsm, rae;
        int          p;
        logic [15:0] model8;

        rst = 1'b0;
        s16 = 0; sm16 = 0; ae16 = 0; a16 = '0; b16 = '0;
        s8 = 0;  sm8 = 0;  ae8 = 0;  a8 = '0;  b8 = '0;
        #2;
        chk("reset busy16", {31'b0, busy16}, 32'd0);
        chk("reset ready16", {31'b0, rdy16}, 32'd0);
        chk("reset out16", out16, 32'd0);
        chk("reset out8", {16'h0, out8}, 32'd0);
        repeat (2) tick;
        rst = 1'b1;
        tick;

        // Basic products, both modes
        run_op(0, 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001, "u ffff*ffff");
        run_op(0, 16'h8000, 16'h8000, 1, 0, 32'h40000000, "s 8000*8000");
        run_op(0, 16'hFFFF, 16'h0002, 1, 0, 32'hFFFFFFFE, "s ffff*2");
        run_op(0, 16'hFFFF, 16'h0002, 0, 0, 32'h0001FFFE, "u ffff*2");

        // Accumulate and silent wrap
        run_op(0, 16'd3, 16'd4, 0, 0, 32'h0000000C, "acc 3*4");
        run_op(0, 16'd5, 16'd6, 0, 1, 32'h0000002A, "acc +5*6");
        run_op(0, 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001, "acc preset");
        run_op(0, 16'hFFFF, 16'h0002, 0, 1, 32'hFFFFFFFF, "acc +1fffe");
        run_op(0, 16'd1, 16'd1, 0, 1, 32'h00000000, "acc wrap");

        // start pulses while busy are ignored; inputs change freely
        a16 = 16'h1234; b16 = 16'h0010; sm16 = 0; ae16 = 0; s16 = 1'b1;
        tick;
        lat = 0;
        while (!rdy16 && lat < 40) begin
            if (lat == 2 || lat == 6) begin
                s16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1; ae16 = 1;
            end else s16 = 1'b0;
            tick;
            lat++;
        end
        s16 = 1'b0;
        chk("ignore latency", 32'(lat), 32'd10);
        chk("ignore out", out16, 32'h00012340);
        tick;
        chk("ignore no restart", {31'b0, busy16}, 32'd0);

        // start held through the ready cycle: back-to-back accept
        a16 = 16'd2; b16 = 16'd3; sm16 = 0; ae16 = 0; s16 = 1'b1;
        tick;
        lat = 0;
        while (!rdy16 && lat < 40) begin tick; lat++; end
        chk("b2b first latency", 32'(lat), 32'd10);
        chk("b2b first out", out16, 32'h00000006);
        a16 = 16'd7; b16 = 16'd8;
        tick;
        s16 = 1'b0;
        chk("b2b accepted", {31'b0, busy16}, 32'd1);
        lat = 0;
        while (!rdy16 && lat < 40) begin tick; lat++; end
        chk("b2b second latency", 32'(lat), 32'd10);
        chk("b2b second out", out16, 32'h00000038);
        tick;

        // Asynchronous reset mid-operation
        a16 = 16'd5; b16 = 16'd5; sm16 = 0; ae16 = 1; s16 = 1'b1;
        tick;
        s16 = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy16}, 32'd0);
        chk("rst ready", {31'b0, rdy16}, 32'd0);
        chk("rst out", out16, 32'd0);
        tick;
        rst = 1'b1;
        cnt_r = 0; cnt_b = 0;
        for (int i = 0; i < 15; i++) begin
            if (rdy16) cnt_r++;
            if (busy16) cnt_b++;
            tick;
        end
        chk("rst no ready", 32'(cnt_r), 32'd0);
        chk("rst no busy", 32'(cnt_b), 32'd0);
        run_op(0, 16'd7, 16'd9, 0, 0, 32'h0000003F, "post-rst 7*9");

        // WIDTH=8 instance
        run_op(1, 16'h0080, 16'h007F, 1, 0, 32'h0000C080, "w8 s 80*7f");
        run_op(1, 16'h00FF, 16'h00FF, 0, 0, 32'h0000FE01, "w8 u ff*ff");
        model8 = 16'hFE01;
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rsm = 1'($urandom);
            rae = 1'($urandom);
            if (rsm) p = int'($signed(ra)) * int'($signed(rb));
            else     p = int'(ra) * int'(rb);
            model8 = rae ? (model8 + p[15:0]) : p[15:0];
            run_op(1, {8'h0, ra}, {8'h0, rb}, rsm, rae, {16'h0, model8}, "w8 rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
